cluster_acc_reduce: RTL and testbench

CLUSTER_ACC_REDUCE -- requirements
Module: cluster_acc_reduce

---
 rtl/cluster_acc_reduce.sv | 159 +++++++++++++++
 tb/tb_cluster_acc_reduce.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cluster_acc_reduce.sv
// cluster_acc_reduce: snapshots N lane accumulators (RGB + pixel count) and
// reduces them LPC lanes per clock into wrapping sum registers with a sticky
// overflow flag, then holds the result under a valid/ready handshake.
module cluster_acc_reduce #(
  parameter int E   = 16,
  parameter int T   = 16,
  parameter int CW  = 24,
  parameter int NW  = 12,
  parameter int LPC = 1,
  localparam int N    = E * T,
  localparam int SW   = CW + $clog2(N),
  localparam int CNTW = NW + $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                accumulate,
  input  logic [N*3*CW-1:0]   acc_in,
  input  logic [N*NW-1:0]     cnt_in,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SW-1:0]       sum_r,
  output logic [SW-1:0]       sum_g,
  output logic [SW-1:0]       sum_b,
  output logic [CNTW-1:0]     sum_cnt,
  output logic                empty,
  output logic                ovf
);

  localparam int LW = 3 * CW;
  localparam int IW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N*LW-1:0]     snap_acc_q, snap_acc_d;
  logic [N*NW-1:0]     snap_cnt_q, snap_cnt_d;
  logic [SW-1:0]       sum_r_q, sum_r_d;
  logic [SW-1:0]       sum_g_q, sum_g_d;
  logic [SW-1:0]       sum_b_q, sum_b_d;
  logic [CNTW-1:0]     sum_cnt_q, sum_cnt_d;
  logic                ovf_q, ovf_d;

  logic [LW-1:0]       lane_acc;
  logic [NW-1:0]       lane_cnt;
  logic [SW:0]         tmp_r, tmp_g, tmp_b;
  logic [CNTW:0]       tmp_cnt;
  int unsigned         lane;

  // Next-state, snapshot capture and per-cycle lane reduction.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_acc_d = snap_acc_q;
    snap_cnt_d = snap_cnt_q;
    sum_r_d    = sum_r_q;
    sum_g_d    = sum_g_q;
    sum_b_d    = sum_b_q;
    sum_cnt_d  = sum_cnt_q;
    ovf_d      = ovf_q;
    lane_acc   = '0;
    lane_cnt   = '0;
    tmp_r      = '0;
    tmp_g      = '0;
    tmp_b      = '0;
    tmp_cnt    = '0;
    lane       = 0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_acc_d = acc_in;
          snap_cnt_d = cnt_in;
          idx_d      = '0;
          if (!accumulate) begin
            sum_r_d   = '0;
            sum_g_d   = '0;
            sum_b_d   = '0;
            sum_cnt_d = '0;
            ovf_d     = 1'b0;
          end
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // Once idx reaches N, one further ACCUM cycle with no addition
        // precedes DONE, placing out_valid N/LPC+1 cycles after start.
        if (idx_q == IW'(N)) begin
          state_d = S_DONE;
        end else begin
          for (int unsigned j = 0; j < LPC; j++) begin
            lane     = 32'(idx_q) + j;
            lane_acc = snap_acc_q[lane*LW +: LW];
            lane_cnt = snap_cnt_q[lane*NW +: NW];
            tmp_r    = {1'b0, sum_r_d} + (SW+1)'(lane_acc[3*CW-1:2*CW]);
            tmp_g    = {1'b0, sum_g_d} + (SW+1)'(lane_acc[2*CW-1:CW]);
            tmp_b    = {1'b0, sum_b_d} + (SW+1)'(lane_acc[CW-1:0]);
            tmp_cnt  = {1'b0, sum_cnt_d} + (CNTW+1)'(lane_cnt);
            if (tmp_r[SW] || tmp_g[SW] || tmp_b[SW] || tmp_cnt[CNTW]) begin
              ovf_d = 1'b1;
            end
            sum_r_d   = tmp_r[SW-1:0];
            sum_g_d   = tmp_g[SW-1:0];
            sum_b_d   = tmp_b[SW-1:0];
            sum_cnt_d = tmp_cnt[CNTW-1:0];
          end
          idx_d = idx_q + IW'(LPC);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, snapshot and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      snap_acc_q <= '0;
      snap_cnt_q <= '0;
      sum_r_q    <= '0;
      sum_g_q    <= '0;
      sum_b_q    <= '0;
      sum_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_acc_q <= snap_acc_d;
      snap_cnt_q <= snap_cnt_d;
      sum_r_q    <= sum_r_d;
      sum_g_q    <= sum_g_d;
      sum_b_q    <= sum_b_d;
      sum_cnt_q  <= sum_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum_r     = sum_r_q;
  assign sum_g     = sum_g_q;
  assign sum_b     = sum_b_q;
  assign sum_cnt   = sum_cnt_q;
  assign empty     = (sum_cnt_q == '0);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cluster_acc_reduce.sv
// Self-checking bench for cluster_acc_reduce (E=2, T=2, LPC=1).
module tb_cluster_acc_reduce;

  localparam int E = 2, T = 2, CW = 24, NW = 12, LPC = 1;
  localparam int N = 4, SW = 26, CNTW = 14;
  localparam longint unsigned SMOD = 64'd1 << SW;
  localparam longint unsigned CMOD = 64'd1 << CNTW;

  logic                clk = 1'b0;
  logic                rst_n, start, accumulate, out_ready;
  logic [N*3*CW-1:0]   acc_in;
  logic [N*NW-1:0]     cnt_in;
  logic                busy, out_valid, empty, ovf;
  logic [SW-1:0]       sum_r, sum_g, sum_b;
  logic [CNTW-1:0]     sum_cnt;

  int tests = 0;
  int fails = 0;

  longint unsigned lr[N], lg[N], lb[N], lc[N];
  longint unsigned mr, mg, mb, mc;
  bit              movf;

  cluster_acc_reduce #(.E(E), .T(T), .CW(CW), .NW(NW), .LPC(LPC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate),
    .acc_in(acc_in), .cnt_in(cnt_in), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .sum_r(sum_r), .sum_g(sum_g), .sum_b(sum_b),
    .sum_cnt(sum_cnt), .empty(empty), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      acc_in[i*3*CW +: 3*CW] = {lr[i][CW-1:0], lg[i][CW-1:0], lb[i][CW-1:0]};
      cnt_in[i*NW +: NW]     = lc[i][NW-1:0];
    end
  endtask

  task automatic set_all(input longint unsigned r, g, b, c);
    for (int i = 0; i < N; i++) begin
      lr[i] = r; lg[i] = g; lb[i] = b; lc[i] = c;
    end
    drive_lanes();
  endtask

  // Reference: the result is the plain-integer total of all lanes added to
  // the held value, reduced modulo the register width; any total reaching
  // the modulus means a carry escaped.
  task automatic model_start(input bit acc);
    longint unsigned tr, tg, tb, tc;
    if (!acc) begin
      mr = 0; mg = 0; mb = 0; mc = 0; movf = 0;
    end
    tr = mr; tg = mg; tb = mb; tc = mc;
    for (int i = 0; i < N; i++) begin
      tr += lr[i]; tg += lg[i]; tb += lb[i]; tc += lc[i];
    end
    if (tr >= SMOD || tg >= SMOD || tb >= SMOD || tc >= CMOD) movf = 1;
    mr = tr % SMOD; mg = tg % SMOD; mb = tb % SMOD; mc = tc % CMOD;
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_r"}, 64'(sum_r), mr);
    chk({tag, "_g"}, 64'(sum_g), mg);
    chk({tag, "_b"}, 64'(sum_b), mb);
    chk({tag, "_cnt"}, 64'(sum_cnt), mc);
    chk({tag, "_empty"}, 64'(empty), 64'(mc == 0));
    chk({tag, "_ovf"}, 64'(ovf), 64'(movf));
  endtask

  // One full transaction; optional DONE stall with start pulses and optional
  // corruption of acc_in while accumulating.
  task automatic do_run(input string tag, input bit acc, input int stall, input bit corrupt);
    int lat;
    @(negedge clk);
    out_ready  = (stall == 0);
    start      = 1'b1;
    accumulate = acc;
    model_start(acc);
    @(posedge clk); #1;
    start      = 1'b0;
    accumulate = 1'b0;
    chk({tag, "_busy_accum"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (corrupt && lat == 2) acc_in = '1;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(N / LPC + 1));
    chk_result(tag);
    for (int k = 0; k < stall; k++) begin
      start = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_stall_r"}, 64'(sum_r), mr);
      chk({tag, "_stall_cnt"}, 64'(sum_cnt), mc);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    drive_lanes();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; out_ready = 1'b1;
    acc_in = '0; cnt_in = '0;
    mr = 0; mg = 0; mb = 0; mc = 0; movf = 0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_r", 64'(sum_r), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic reduction.
    set_all(255, 128, 1, 1);
    do_run("basic", 1'b0, 0, 1'b0);
    chk("basic_r_const", 64'(sum_r), 64'd1020);
    chk("basic_g_const", 64'(sum_g), 64'd512);
    chk("basic_b_const", 64'(sum_b), 64'd4);
    chk("basic_cnt_const", 64'(sum_cnt), 64'd4);
    chk("held_idle_r", 64'(sum_r), mr);

    // Accumulate on top of the held result.
    do_run("accum", 1'b1, 0, 1'b0);
    chk("accum_r_const", 64'(sum_r), 64'd2040);
    chk("accum_cnt_const", 64'(sum_cnt), 64'd8);

    // Empty cluster.
    set_all(0, 0, 0, 0);
    do_run("empty", 1'b0, 0, 1'b0);
    chk("empty_flag_const", 64'(empty), 64'd1);

    // Backpressure with start pulses during the stall.
    set_all(255, 128, 1, 1);
    do_run("bp", 1'b0, 3, 1'b0);

    // Overflow: full-scale red, once cleared, once accumulated.
    set_all(16777215, 0, 0, 1);
    do_run("ovf1", 1'b0, 0, 1'b0);
    chk("ovf1_r_const", 64'(sum_r), 64'd67108860);
    chk("ovf1_ovf_const", 64'(ovf), 64'd0);
    do_run("ovf2", 1'b1, 0, 1'b0);
    chk("ovf2_r_const", 64'(sum_r), 64'd67108856);
    chk("ovf2_ovf_const", 64'(ovf), 64'd1);
    set_all(0, 0, 0, 1);
    do_run("ovf_sticky", 1'b1, 0, 1'b0);
    do_run("ovf_clear", 1'b0, 0, 1'b0);

    // Snapshot isolation.
    set_all(255, 128, 1, 1);
    do_run("snap", 1'b0, 0, 1'b1);
    chk("snap_r_const", 64'(sum_r), 64'd1020);

    // Reset mid-ACCUM, checked without any clock edge.
    @(negedge clk);
    start = 1'b1; accumulate = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_r", 64'(sum_r), 64'd0);
    chk("mid_rst_cnt", 64'(sum_cnt), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    mr = 0; mg = 0; mb = 0; mc = 0; movf = 0;
    @(negedge clk); rst_n = 1'b1;
    do_run("post_rst", 1'b1, 0, 1'b0);
    chk("post_rst_r_const", 64'(sum_r), 64'd1020);

    // Randomized transactions against the reference.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < N; i++) begin
        lr[i] = ($urandom_range(0, 2) == 0) ? 64'hFFFFFF : 64'($urandom & 32'hFFFFFF);
        lg[i] = 64'($urandom & 32'hFFFFFF);
        lb[i] = ($urandom_range(0, 3) == 0) ? 64'hFFFFFF : 64'($urandom_range(0, 1000));
        lc[i] = (n % 4 == 3) ? 64'd0 : 64'($urandom & 32'hFFF);
      end
      drive_lanes();
      do_run($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
